uart_io_ctrl: RTL and testbench

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

---
 rtl/uart_io_pkg.sv | 41 ++++
 rtl/uart_rd_mux.sv | 31 +++
 rtl/uart_io_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART processor I/O controller: register offsets,
// STATUS/CTRL bit positions and TX/interrupt FSM state encodings.
package uart_io_pkg;

    localparam int NUM_REGS   = 3;
    localparam int OFF_DATA   = 0;
    localparam int OFF_STATUS = 1;
    localparam int OFF_CTRL   = 2;

    localparam int ST_RXF   = 0;
    localparam int ST_TXRDY = 1;
    localparam int ST_FERR  = 2;
    localparam int ST_PERR  = 3;
    localparam int ST_OVF   = 4;
    localparam int ST_TXOVF = 5;

    localparam int CTRL_RXIE = 0;
    localparam int CTRL_TXIE = 1;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_LOAD = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;

    localparam logic [0:0] INT_IDLE = 1'b0;
    localparam logic [0:0] INT_REQ  = 1'b1;

    // Field order matches the STATUS byte from bit 5 down to bit 0.
    typedef struct packed {
        logic txovf;
        logic ovf;
        logic perr;
        logic ferr;
        logic txrdy;
        logic rxf;
    } status_t;

    function automatic logic [7:0] status_byte(input status_t st);
        return {2'b00, st};
    endfunction

endpackage

// File: rtl/uart_rd_mux.sv
// Combinational processor read-back mux for the three-register window at BASE_ADDR.
module uart_rd_mux
    import uart_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic [15:0] port_id,
    input  logic [7:0]  rx_hold,
    input  logic [7:0]  status,
    input  logic [7:0]  ctrl,
    output logic [15:0] in_port
);

    logic [NUM_REGS-1:0] hit;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        assign hit[gi] = (port_id == BASE_ADDR + 16'(gi));
    end

    always_comb begin
        in_port = 16'h0000;
        if (hit[OFF_DATA]) begin
            in_port = {8'h00, rx_hold};
        end else if (hit[OFF_STATUS]) begin
            in_port = {8'h00, status};
        end else if (hit[OFF_CTRL]) begin
            in_port = {8'h00, ctrl};
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// Processor-port register front end for a UART: RX holding/status flags, TX load
// FSM and a level interrupt. Define UART_TX_BUF_EN to add a one-entry TX buffer.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] port_id,
    input  logic        read_strobe,
    input  logic        write_strobe,
    input  logic [15:0] out_port,
    output logic [15:0] in_port,
    output logic        interrupt,
    input  logic        interrupt_ack,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    input  logic        rx_ferr,
    input  logic        rx_perr,
    input  logic        tx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_load
);

    logic [NUM_REGS-1:0] sel;
    logic rd_data, rd_status, wr_data, wr_ctrl;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sel
        assign sel[gi] = (port_id == BASE_ADDR + 16'(gi));
    end

    assign rd_data   = read_strobe  & sel[OFF_DATA];
    assign rd_status = read_strobe  & sel[OFF_STATUS];
    assign wr_data   = write_strobe & sel[OFF_DATA];
    assign wr_ctrl   = write_strobe & sel[OFF_CTRL];

    logic [7:0] rx_hold_reg, rx_hold_next;
    logic       rxf_reg, rxf_next;
    logic       ovf_reg, ovf_next;
    logic       ferr_reg, ferr_next;
    logic       perr_reg, perr_next;
    logic       txovf_reg, txovf_next;
    logic [1:0] ctrl_reg, ctrl_next;
    logic [1:0] tx_state_reg, tx_state_next;
    logic [7:0] tx_data_reg, tx_data_next;
    logic [0:0] int_state_reg, int_state_next;
    logic       rxf_d_reg, txrdy_d_reg;
    logic       txrdy, direct_ok, txovf_set, int_event;
    status_t    status;

`ifdef UART_TX_BUF_EN
    logic       buf_full_reg, buf_full_next;
    logic [7:0] buf_data_reg, buf_data_next;

    always_comb begin
        buf_full_next = buf_full_reg;
        buf_data_next = buf_data_reg;
        if (tx_state_reg == TX_IDLE && tx_rdy && buf_full_reg) begin
            buf_full_next = 1'b0;
        end
        if (wr_data && !direct_ok && !buf_full_reg) begin
            buf_full_next = 1'b1;
            buf_data_next = out_port[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full_reg <= 1'b0;
            buf_data_reg <= 8'h00;
        end else begin
            buf_full_reg <= buf_full_next;
            buf_data_reg <= buf_data_next;
        end
    end

    // A full buffer rejects the write even if it drains this cycle.
    assign txovf_set = wr_data & ~direct_ok & buf_full_reg;
`else
    logic       buf_full_reg;
    logic [7:0] buf_data_reg;
    assign buf_full_reg = 1'b0;
    assign buf_data_reg = 8'h00;
    assign txovf_set    = wr_data & ~direct_ok;
`endif

    assign txrdy     = (tx_state_reg == TX_IDLE) & tx_rdy & ~buf_full_reg;
    assign direct_ok = txrdy;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_data_next  = tx_data_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_rdy) begin
                    if (buf_full_reg) begin
                        tx_state_next = TX_LOAD;
                        tx_data_next  = buf_data_reg;
                    end else if (wr_data) begin
                        tx_state_next = TX_LOAD;
                        tx_data_next  = out_port[7:0];
                    end
                end
            end
            TX_LOAD: tx_state_next = TX_WAIT;
            // The transmitter dropping tx_rdy confirms it took the byte.
            TX_WAIT: if (!tx_rdy) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Set events take priority over read-side clears.
    always_comb begin
        rx_hold_next = rx_rdy ? rx_data : rx_hold_reg;
        rxf_next     = rx_rdy | (rxf_reg & ~rd_data);
        ovf_next     = (rx_rdy & rxf_reg & ~rd_data) | (ovf_reg & ~rd_status);
        ferr_next    = (rx_rdy & rx_ferr) | (ferr_reg & ~rd_status);
        perr_next    = (rx_rdy & rx_perr) | (perr_reg & ~rd_status);
        txovf_next   = txovf_set | (txovf_reg & ~rd_status);
        ctrl_next    = wr_ctrl ? out_port[1:0] : ctrl_reg;
    end

    assign int_event = (rxf_reg & ~rxf_d_reg & ctrl_reg[CTRL_RXIE])
                     | (txrdy & ~txrdy_d_reg & ctrl_reg[CTRL_TXIE]);

    // Events arriving while a request is outstanding are discarded, not queued.
    always_comb begin
        int_state_next = int_state_reg;
        case (int_state_reg)
            INT_IDLE: if (int_event) int_state_next = INT_REQ;
            INT_REQ:  if (interrupt_ack) int_state_next = INT_IDLE;
            default:  int_state_next = INT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_hold_reg   <= 8'h00;
            rxf_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            ferr_reg      <= 1'b0;
            perr_reg      <= 1'b0;
            txovf_reg     <= 1'b0;
            ctrl_reg      <= 2'b00;
            tx_state_reg  <= TX_IDLE;
            tx_data_reg   <= 8'h00;
            int_state_reg <= INT_IDLE;
            rxf_d_reg     <= 1'b0;
            txrdy_d_reg   <= 1'b0;
        end else begin
            rx_hold_reg   <= rx_hold_next;
            rxf_reg       <= rxf_next;
            ovf_reg       <= ovf_next;
            ferr_reg      <= ferr_next;
            perr_reg      <= perr_next;
            txovf_reg     <= txovf_next;
            ctrl_reg      <= ctrl_next;
            tx_state_reg  <= tx_state_next;
            tx_data_reg   <= tx_data_next;
            int_state_reg <= int_state_next;
            rxf_d_reg     <= rxf_reg;
            txrdy_d_reg   <= txrdy;
        end
    end

    always_comb begin
        status       = '0;
        status.rxf   = rxf_reg;
        status.txrdy = txrdy;
        status.ferr  = ferr_reg;
        status.perr  = perr_reg;
        status.ovf   = ovf_reg;
        status.txovf = txovf_reg;
    end

    uart_rd_mux #(
        .BASE_ADDR(BASE_ADDR)
    ) u_rd_mux (
        .port_id(port_id),
        .rx_hold(rx_hold_reg),
        .status (status_byte(status)),
        .ctrl   ({6'b000000, ctrl_reg}),
        .in_port(in_port)
    );

    assign tx_load   = (tx_state_reg == TX_LOAD);
    assign tx_data   = tx_data_reg;
    assign interrupt = (int_state_reg == INT_REQ);

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: a cycle-level reference model predicts
// outputs per cycle; a negedge monitor pops and compares them.
module tb_uart_io_ctrl;

    localparam logic [15:0] BASE = 16'h0040;
`ifdef UART_TX_BUF_EN
    localparam logic [15:0] TXOVF_READ = 16'h0000;
`else
    localparam logic [15:0] TXOVF_READ = 16'h0020;
`endif

    logic        clk = 1'b0;
    logic        reset, read_strobe, write_strobe, interrupt_ack;
    logic [15:0] port_id, out_port, in_port;
    logic        interrupt, rx_rdy, rx_ferr, rx_perr, tx_rdy, tx_load;
    logic [7:0]  rx_data, tx_data;

    always #5 clk = ~clk;

    uart_io_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .port_id(port_id),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .out_port(out_port), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ferr(rx_ferr), .rx_perr(rx_perr),
        .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_load(tx_load)
    );

    typedef struct {
        bit          chk_in;
        logic [15:0] in_port;
        logic        tx_load;
        logic [7:0]  tx_data;
        logic        interrupt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_no = 0;

    // Reference model state
    bit [7:0] m_hold, m_txd, m_buf;
    bit       m_rxf, m_ovf, m_ferr, m_perr, m_txovf, m_buf_full, m_int;
    bit       m_prev_rxf, m_prev_txrdy;
    bit [1:0] m_ctrl;
    int       m_phase;  // 0: idle, 1: load pulse, 2: waiting for transmitter busy

    task automatic model_reset();
        m_hold = 0; m_txd = 0; m_buf = 0; m_rxf = 0; m_ovf = 0; m_ferr = 0;
        m_perr = 0; m_txovf = 0; m_buf_full = 0; m_int = 0; m_prev_rxf = 0;
        m_prev_txrdy = 0; m_ctrl = 0; m_phase = 0;
    endtask

    function automatic bit model_txrdy(input bit txr);
        return (m_phase == 0) && txr && !m_buf_full;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] pid, input bit txr);
        if (pid == BASE)     return {8'h00, m_hold};
        if (pid == BASE + 1) return {10'h000, m_txovf, m_ovf, m_perr, m_ferr, model_txrdy(txr), m_rxf};
        if (pid == BASE + 2) return {14'h0000, m_ctrl};
        return 16'h0000;
    endfunction

    task automatic model_update(input bit rst, input bit rd, input bit wr,
                                input logic [15:0] pid, input logic [15:0] wd,
                                input bit rrdy, input logic [7:0] rdat,
                                input bit fe, input bit pe, input bit txr, input bit ack);
        bit rd0, rd1, wr0, wr2, trdy, ev, old_full, took;
        if (rst) begin
            model_reset();
            return;
        end
        rd0 = rd && pid == BASE;
        rd1 = rd && pid == BASE + 1;
        wr0 = wr && pid == BASE;
        wr2 = wr && pid == BASE + 2;
        trdy = model_txrdy(txr);
        ev = (m_rxf && !m_prev_rxf && m_ctrl[0]) || (trdy && !m_prev_txrdy && m_ctrl[1]);
        m_prev_rxf = m_rxf;
        m_prev_txrdy = trdy;
        m_int = m_int ? !ack : ev;
        if (rd1) begin m_ovf = 0; m_perr = 0; m_ferr = 0; m_txovf = 0; end
        if (rrdy && m_rxf && !rd0) m_ovf = 1;
        if (rd0) m_rxf = 0;
        if (rrdy) begin
            m_hold = rdat; m_rxf = 1;
            if (fe) m_ferr = 1;
            if (pe) m_perr = 1;
        end
        old_full = m_buf_full;
        took = 0;
        case (m_phase)
            0: if (txr && m_buf_full) begin
                   m_phase = 1; m_txd = m_buf; m_buf_full = 0;
               end else if (txr && wr0) begin
                   m_phase = 1; m_txd = wd[7:0]; took = 1;
               end
            1: m_phase = 2;
            default: if (!txr) m_phase = 0;
        endcase
        if (wr0 && !took) begin
`ifdef UART_TX_BUF_EN
            if (old_full) m_txovf = 1;
            else begin m_buf_full = 1; m_buf = wd[7:0]; end
`else
            m_txovf = 1;
`endif
        end
        if (wr2) m_ctrl = wd[1:0];
    endtask

    task automatic step(input bit rst, input bit rd, input bit wr, input logic [15:0] pid,
                        input logic [15:0] wd, input bit rrdy, input logic [7:0] rdat,
                        input bit fe, input bit pe, input bit txr, input bit ack,
                        input bit use_const, input logic [15:0] cval);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; read_strobe = rd; write_strobe = wr; port_id = pid; out_port = wd;
        rx_rdy = rrdy; rx_data = rdat; rx_ferr = fe; rx_perr = pe; tx_rdy = txr;
        interrupt_ack = ack;
        e.chk_in    = rd;
        e.in_port   = use_const ? cval : model_read(pid, txr);
        e.tx_load   = (m_phase == 1);
        e.tx_data   = m_txd;
        e.interrupt = m_int;
        e.cyc       = cyc_no;
        cyc_no++;
        exp_q.push_back(e);
        model_update(rst, rd, wr, pid, wd, rrdy, rdat, fe, pe, txr, ack);
    endtask

    task automatic idle(input int n, input bit txr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, txr, 0, 0, 0);
    endtask
    task automatic rd_const(input logic [15:0] a, input bit txr, input logic [15:0] v);
        step(0, 1, 0, a, 0, 0, 0, 0, 0, txr, 0, 1, v);
    endtask
    task automatic wr_reg(input logic [15:0] a, input logic [15:0] d, input bit txr);
        step(0, 0, 1, a, d, 0, 0, 0, 0, txr, 0, 0, 0);
    endtask
    task automatic rx_byte(input logic [7:0] d, input bit txr);
        step(0, 0, 0, 16'hFFFF, 0, 1, d, 0, 0, txr, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv, input int c);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_load", {15'h0, tx_load}, {15'h0, e.tx_load}, e.cyc);
            check("tx_data", {8'h0, tx_data}, {8'h0, e.tx_data}, e.cyc);
            check("interrupt", {15'h0, interrupt}, {15'h0, e.interrupt}, e.cyc);
            if (e.chk_in) check("in_port", in_port, e.in_port, e.cyc);
            $display("[TB] cycle %0d rd=%0b port=%h in_port=%h tx_load=%0b tx_data=%h int=%0b",
                     e.cyc, read_strobe, port_id, in_port, tx_load, tx_data, interrupt);
        end
    end

    initial begin
        bit txr_v;
        int pick;
        logic [15:0] pid;
        reset = 1; read_strobe = 0; write_strobe = 0; port_id = 0; out_port = 0;
        rx_rdy = 0; rx_data = 0; rx_ferr = 0; rx_perr = 0; tx_rdy = 1; interrupt_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset state and unmapped read
        rd_const(BASE + 1, 1, 16'h0002);
        rd_const(BASE,     1, 16'h0000);
        rd_const(BASE + 2, 1, 16'h0000);
        rd_const(BASE + 3, 1, 16'h0000);

        // Single byte receive, read clears RXF
        rx_byte(8'hA5, 1);
        rd_const(BASE + 1, 1, 16'h0003);
        rd_const(BASE,     1, 16'h00A5);
        rd_const(BASE + 1, 1, 16'h0002);

        // Overrun: second byte overwrites, OVF cleared by STATUS read
        rx_byte(8'h11, 1);
        rx_byte(8'h22, 1);
        rd_const(BASE + 1, 1, 16'h0013);
        rd_const(BASE + 1, 1, 16'h0003);
        rd_const(BASE,     1, 16'h0022);

        // RX interrupt held without ack, then acknowledged
        wr_reg(BASE + 2, 16'h0001, 1);
        rx_byte(8'h5A, 1);
        idle(6, 1);
        step(0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(2, 1);
        rd_const(BASE, 1, 16'h005A);
        wr_reg(BASE + 2, 16'h0000, 1);

        // TX load, then a write while the transmitter is busy
        wr_reg(BASE, 16'h003C, 1);
        idle(2, 0);
        wr_reg(BASE, 16'h0077, 0);
        rd_const(BASE + 1, 0, TXOVF_READ);
        idle(3, 1);
        idle(1, 0);
        idle(2, 1);

        // FERR set wins over STATUS-read clear
        step(0, 1, 0, BASE + 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, BASE + 1, 0, 1, 8'h33, 1, 0, 1, 0, 0, 0);
        rd_const(BASE + 1, 1, 16'h0007);
        rd_const(BASE, 1, 16'h0033);
        step(0, 1, 0, BASE + 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset during LOAD aborts the transfer
        wr_reg(BASE, 16'h005E, 1);
        step(1, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd_const(BASE + 1, 0, 16'h0000);
        idle(4, 1);

        // Randomized traffic
        txr_v = 1;
        for (int i = 0; i < 3000; i++) begin
            bit rd, wr, rrdy;
            if ($urandom_range(0, 3) == 0) txr_v = ~txr_v;
            pick = $urandom_range(0, 7);
            pid = (pick < 4) ? BASE + 16'(pick) : 16'($urandom);
            rd = ($urandom_range(0, 3) == 0);
            wr = !rd && ($urandom_range(0, 4) == 0);
            rrdy = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 499) == 0), rd, wr, pid, 16'($urandom), rrdy, 8'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), txr_v,
                 ($urandom_range(0, 5) == 0), 0, 0);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
